uart_tx_buffered: RTL and testbench

//  - Buffered UART transmitter: the outbound counterpart of UART_RX.
//  - Accepts bytes over a valid/ready write port into a small FIFO.
//  - Serialises them 8N1 (LSB first) on tx, back-to-back, with no host pacing.
//  - Sits between core logic and the board TX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_tx_buffered.sv | 149 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: UART state encoding, line idle level and frame-length helper shared by TX and RX.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity_bits, input int stop_bits);
    return (1 + data_bits + parity_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// uart_sync_fifo: single-clock FIFO with show-ahead read data, full/empty flags and occupancy count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on count alone, so a full FIFO refuses a push even while popping.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// uart_tx_buffered: FIFO-fed 8N1 UART transmitter with back-to-back frames.
// Optional even parity bit after the data when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + STOP_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_t             state, state_n;
  logic [BAUD_W-1:0]     baud, baud_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n;
  logic [DATA_BITS-1:0]  shift, shift_n;
  logic                  baud_end;
  logic                  load;
  logic                  fifo_pop;
  logic [DATA_BITS-1:0]  fifo_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef UART_TX_PARITY_EN
  logic                  par, par_n;
`endif

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr_ready = !fifo_full;
  assign busy     = (state != IDLE) || (fifo_count != '0);
  assign baud_end = (baud == BAUD_LAST);

  always_comb begin
    state_n  = state;
    bit_n    = bit_cnt;
    shift_n  = shift;
    load     = 1'b0;
    done     = 1'b0;
    tx       = UART_IDLE_LEVEL;
    baud_n   = (state == IDLE || baud_end) ? '0 : baud + 1'b1;
`ifdef UART_TX_PARITY_EN
    par_n    = par;
`endif
    case (state)
      IDLE: load = !fifo_empty;
      START: begin
        tx = 1'b0;
        if (baud_end) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        tx = shift[0];
        if (baud_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = par;
        if (baud_end) begin
          state_n = STOP;
          bit_n   = '0;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          if (bit_cnt == STOP_LAST) begin
            done    = 1'b1;
            // Chain straight into the next start bit when more data is queued.
            load    = !fifo_empty;
            state_n = IDLE;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = START;
      shift_n = fifo_data;
      bit_n   = '0;
`ifdef UART_TX_PARITY_EN
      par_n   = ^fifo_data;
`endif
    end
    fifo_pop = load;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// tb_uart_tx_buffered: directed stimulus with a serial-line monitor scoreboard for uart_tx_buffered.
module tb_uart_tx_buffered;
  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
  localparam int FRAME_HAND = 44;
`else
  localparam int PAR = 0;
  localparam int FRAME_HAND = 40;
`endif
  localparam int FRAME = uart_pkg::frame_cycles(CPB, DB, PAR, 1);

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic       done;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  longint     cyc = 0;
  logic [7:0] exp_q[$];
  longint     done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst && done) done_q.push_back(cyc);

  // Serial monitor: finds each start bit, samples mid-bit and scores the frame.
  bit         active = 1'b0;
  int         t = 0;
  logic [7:0] rx_byte;
  logic [7:0] e;
`ifdef UART_TX_PARITY_EN
  logic       rx_par;
`endif
  always @(negedge clk) begin
    if (!rst) begin
      active = 1'b0;
    end else begin
      if (!active && tx == 1'b0) begin
        active  = 1'b1;
        t       = 0;
        rx_byte = '0;
      end
      if (active) begin
        if (t == 2) check("start_bit", {31'd0, tx}, 32'd0);
        if (t >= CPB && t < CPB * (1 + DB) && (t % CPB) == 2) rx_byte[t / CPB - 1] = tx;
`ifdef UART_TX_PARITY_EN
        if (t == CPB * (1 + DB) + 2) rx_par = tx;
`endif
        if (t == FRAME - 2) begin
          check("stop_bit", {31'd0, tx}, 32'd1);
          check("done_early", {31'd0, done}, 32'd0);
        end
        if (t == FRAME - 1) begin
          check("done_at_end", {31'd0, done}, 32'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", {24'd0, rx_byte}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
            check("parity_bit", {31'd0, rx_par}, {31'd0, ^e});
`endif
          end
          active = 1'b0;
        end
        t++;
      end
    end
  end

  task automatic push(input logic [7:0] d, output longint acc);
    acc      = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (wr_ready) begin
        acc = cyc + 1;
        exp_q.push_back(d);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_data  = ~d;
        return;
      end
      @(negedge clk);
    end
    check("push_timeout", 32'd0, 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy && !active) return;
    end
    check(name, 32'd0, 32'd1);
  endtask

  longint     a0, a1, a2;
  logic [7:0] rdy_exp;
  bit         got;

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;

    // 1. reset
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // 2. single frame 8'h8A
    done_q.delete();
    push(8'h8A, a0);
    check("latency_pre", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("latency_start", {31'd0, tx}, 32'd0);
    wait_idle("t2_timeout");
    check("t2_done_count", done_q.size(), 32'd1);
    if (done_q.size() >= 1) check("t2_frame_len", 32'(done_q[0] - a0), FRAME_HAND);
    check("t2_busy_after", {31'd0, busy}, 32'd0);

    // 3. three back-to-back frames
    done_q.delete();
    push(8'h55, a0);
    push(8'hA3, a1);
    push(8'hFF, a2);
    wait_idle("t3_timeout");
    check("t3_done_count", done_q.size(), 32'd3);
    if (done_q.size() == 3) begin
      check("t3_first_done", 32'(done_q[0] - a0), FRAME_HAND);
      check("t3_gap1", 32'(done_q[1] - done_q[0]), FRAME_HAND);
      check("t3_gap2", 32'(done_q[2] - done_q[1]), FRAME_HAND);
    end

    // 4. hold wr_valid for 8 cycles: 5 accepted, 3 refused
    rdy_exp = 8'b0001_1111;
    for (int i = 0; i < 8; i++) begin
      wr_data  = 8'h10 + 8'(i);
      wr_valid = 1'b1;
      check("t4_wr_ready", {31'd0, wr_ready}, {31'd0, rdy_exp[i]});
      if (wr_ready) exp_q.push_back(wr_data);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("t4_done_seen", {31'd0, got}, 32'd1);
    check("t4_ready_at_done", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    check("t4_ready_after_pop", {31'd0, wr_ready}, 32'd1);
    wait_idle("t4_timeout");
    check("t4_queue_drained", exp_q.size(), 32'd0);

    // 5. reset mid-data of 8'h8A
    push(8'h8A, a0);
    repeat (14) @(negedge clk);
    check("t5_tx_mid_data", {31'd0, tx}, 32'd0);
    #1 rst = 1'b0;
    #1 check("t5_tx_async", {31'd0, tx}, 32'd1);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_done", {31'd0, done}, 32'd0);
      check("t5_wr_ready", {31'd0, wr_ready}, 32'd1);
    end
    rst = 1'b1;
    done_q.delete();
    @(negedge clk);
    push(8'h3C, a0);
    wait_idle("t5_timeout");
    check("t5_done_count", done_q.size(), 32'd1);

    // 6. loopback-style decode of 8'hC4, 8'h01
    done_q.delete();
    push(8'hC4, a0);
    push(8'h01, a1);
    wait_idle("t6_timeout");
    check("t6_done_count", done_q.size(), 32'd2);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
